// File: rtl/qspi_ram_responder.sv
// qspi_ram_responder: quad-mode QSPI PSRAM target with a byte-wide internal memory.
// qspi_clk and qspi_cs_n are oversampled on clk. Reads (0xEB) and writes (0x38)
// use quad transfers for every phase. Any other opcode is ignored and sets bad_cmd.
// Optional macro QSPI_RESP_LATENCY_EN inserts a selectable 0..7 clk output delay
// (latency_cfg) to model board latency.
module qspi_ram_responder #(
    parameter int ADDR_BITS    = 8,
    parameter int DUMMY_CYCLES = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       qspi_clk,
    input  logic       qspi_cs_n,
    input  logic [3:0] qspi_data_in,
    output logic [3:0] qspi_data_out,
    output logic [3:0] qspi_data_oe,
    input  logic [2:0] latency_cfg,
    output logic       busy,
    output logic       bad_cmd
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE
    } state_t;

    state_t                 state;
    logic                   clk_q;
    logic                   rise, fall;
    logic [3:0]             op_hi;
    logic [2:0]             nib_cnt;
    logic [7:0]             dcnt;
    logic [ADDR_BITS-1:0]   addr;
    logic                   half;
    logic [3:0]             wr_hi;
    logic                   is_read;
    logic [3:0]             core_data;
    logic [3:0]             core_oe;
    logic [7:0]             mem [2**ADDR_BITS];
    logic [7:0]             rd_byte;
    logic                   mem_we;

    assign rise    = qspi_clk & ~clk_q;
    assign fall    = ~qspi_clk & clk_q;
    assign rd_byte = mem[addr];
    assign busy    = (state != IDLE);

    // A byte is committed only on the low-nibble rise; a deselect or reset before
    // then leaves the memory untouched.
    assign mem_we = ~rst & ~qspi_cs_n & (state == WRITE) & rise & half;

    // Memory array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[addr] <= {wr_hi, qspi_data_in};
    end

    // Transaction FSM: decodes the command, address and dummy phases, serves read
    // nibbles on qspi_clk falls and collects write nibbles on rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            clk_q     <= 1'b0;
            op_hi     <= '0;
            nib_cnt   <= '0;
            dcnt      <= '0;
            addr      <= '0;
            half      <= 1'b0;
            wr_hi     <= '0;
            is_read   <= 1'b0;
            core_data <= '0;
            core_oe   <= '0;
            bad_cmd   <= 1'b0;
        end else begin
            clk_q <= qspi_clk;
            if (qspi_cs_n) begin
                // Deselect wins over any simultaneous qspi_clk edge.
                state     <= IDLE;
                nib_cnt   <= '0;
                dcnt      <= '0;
                half      <= 1'b0;
                core_oe   <= '0;
                core_data <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= CMD;
                        nib_cnt <= '0;
                    end
                    CMD: if (rise) begin
                        op_hi <= qspi_data_in;
                        if (nib_cnt == 3'd1) begin
                            nib_cnt <= '0;
                            case ({op_hi, qspi_data_in})
                                8'hEB: begin is_read <= 1'b1; state <= ADDR; end
                                8'h38: begin is_read <= 1'b0; state <= ADDR; end
                                default: begin bad_cmd <= 1'b1; state <= IGNORE; end
                            endcase
                        end else begin
                            nib_cnt <= nib_cnt + 3'd1;
                        end
                    end
                    ADDR: if (rise) begin
                        // Shifting keeps only the low ADDR_BITS of the 24-bit address.
                        addr <= ADDR_BITS'({addr, qspi_data_in});
                        if (nib_cnt == 3'd5) begin
                            nib_cnt <= '0;
                            half    <= 1'b0;
                            dcnt    <= '0;
                            if (!is_read)
                                state <= WRITE;
                            else if (DUMMY_CYCLES == 0)
                                state <= READ;
                            else
                                state <= DUMMY;
                        end else begin
                            nib_cnt <= nib_cnt + 3'd1;
                        end
                    end
                    DUMMY: if (rise) begin
                        if (dcnt == 8'(DUMMY_CYCLES - 1))
                            state <= READ;
                        else
                            dcnt <= dcnt + 8'd1;
                    end
                    READ: if (fall) begin
                        core_oe   <= 4'hF;
                        core_data <= half ? rd_byte[3:0] : rd_byte[7:4];
                        half      <= ~half;
                        if (half)
                            addr <= addr + ADDR_BITS'(1);
                    end
                    WRITE: if (rise) begin
                        if (half) begin
                            addr <= addr + ADDR_BITS'(1);
                            half <= 1'b0;
                        end else begin
                            wr_hi <= qspi_data_in;
                            half  <= 1'b1;
                        end
                    end
                    IGNORE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef QSPI_RESP_LATENCY_EN
    logic [7:1][3:0] dly_data;
    logic [7:1][3:0] dly_oe;

    // Output delay line; deselect or reset clears output enable in every stage.
    always_ff @(posedge clk) begin
        if (rst || qspi_cs_n) begin
            dly_data <= '0;
            dly_oe   <= '0;
        end else begin
            dly_data <= {dly_data[6:1], core_data};
            dly_oe   <= {dly_oe[6:1], core_oe};
        end
    end

    // Tap select: 0 bypasses the delay line entirely.
    always_comb begin
        qspi_data_out = core_data;
        qspi_data_oe  = core_oe;
        if (latency_cfg != 3'd0) begin
            qspi_data_out = dly_data[latency_cfg];
            qspi_data_oe  = dly_oe[latency_cfg];
        end
    end
`else
    logic unused_latency_cfg;
    assign unused_latency_cfg = ^latency_cfg;
    assign qspi_data_out      = core_data;
    assign qspi_data_oe       = core_oe;
`endif

endmodule

// File: tb/tb_qspi_ram_responder.sv
// Directed bench for qspi_ram_responder (ADDR_BITS=8, DUMMY_CYCLES=6).
// Inputs change on the falling edge of clk; outputs are sampled there too.
module tb_qspi_ram_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       qspi_clk;
    logic       qspi_cs_n;
    logic [3:0] qspi_data_in;
    logic [3:0] qspi_data_out;
    logic [3:0] qspi_data_oe;
    logic [2:0] latency_cfg;
    logic       busy;
    logic       bad_cmd;

    int         vectors = 0;
    int         errs    = 0;
    logic [3:0] rd  [8];
    logic [3:0] rdo [8];
    logic [3:0] obs_n;

    qspi_ram_responder #(.ADDR_BITS(8), .DUMMY_CYCLES(6)) dut (
        .clk(clk), .rst(rst), .qspi_clk(qspi_clk), .qspi_cs_n(qspi_cs_n),
        .qspi_data_in(qspi_data_in), .qspi_data_out(qspi_data_out),
        .qspi_data_oe(qspi_data_oe), .latency_cfg(latency_cfg),
        .busy(busy), .bad_cmd(bad_cmd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One qspi_clk period; returns the target's output just before the rise.
    task automatic pulse(input logic [3:0] nib, output logic [3:0] obs, output logic [3:0] oe);
        qspi_data_in = nib;
        wait_n(2);
        obs = qspi_data_out;
        oe  = qspi_data_oe;
        qspi_clk = 1'b1;
        wait_n(2);
        qspi_clk = 1'b0;
        wait_n(1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [3:0] o, e;
        pulse(b[7:4], o, e);
        pulse(b[3:0], o, e);
    endtask

    task automatic start(input logic [7:0] op, input logic [23:0] a);
        qspi_cs_n = 1'b0;
        wait_n(2);
        send_byte(op);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic stop();
        qspi_cs_n = 1'b1;
        qspi_clk  = 1'b0;
        wait_n(2);
    endtask

    // Read n nibbles starting at address a; cs_n is left low for the caller.
    task automatic read_nibs(input logic [23:0] a, input int n);
        logic [3:0] o, e;
        start(8'hEB, a);
        for (int i = 0; i < 6; i++) pulse(4'h0, o, e);
        for (int i = 0; i < n; i++) begin
            pulse(4'h0, o, e);
            rd[i]  = o;
            rdo[i] = e;
        end
    endtask

`ifdef QSPI_RESP_LATENCY_EN
    // Clocks from the final dummy fall until output enable appears.
    task automatic oe_latency(input logic [2:0] cfg, output int lat);
        logic [3:0] o, e;
        latency_cfg = cfg;
        start(8'hEB, 24'h000010);
        for (int i = 0; i < 5; i++) pulse(4'h0, o, e);
        wait_n(2);
        qspi_clk = 1'b1;
        wait_n(2);
        qspi_clk = 1'b0;
        lat = 0;
        while (qspi_data_oe != 4'hF && lat < 20) begin
            wait_n(1);
            lat++;
        end
        stop();
    endtask
`endif

    initial begin
        logic [3:0] o, e;
        rst = 1'b1; qspi_clk = 1'b0; qspi_cs_n = 1'b1; qspi_data_in = 4'h0; latency_cfg = 3'd0;
        wait_n(3);
        chk("reset_oe",   {4'h0, qspi_data_oe},  8'h00);
        chk("reset_out",  {4'h0, qspi_data_out}, 8'h00);
        chk("reset_busy", {7'h0, busy},          8'h00);
        chk("reset_bad",  {7'h0, bad_cmd},       8'h00);
        rst = 1'b0;
        wait_n(2);

        // 1: write A5 3C at 0x10, read it back
        start(8'h38, 24'h000010);
        chk("wr_busy", {7'h0, busy}, 8'h01);
        send_byte(8'hA5);
        send_byte(8'h3C);
        stop();
        read_nibs(24'h000010, 4);
        chk("t1_n0", {4'h0, rd[0]}, 8'h0A);
        chk("t1_n1", {4'h0, rd[1]}, 8'h05);
        chk("t1_n2", {4'h0, rd[2]}, 8'h03);
        chk("t1_n3", {4'h0, rd[3]}, 8'h0C);
        chk("t1_oe", {4'h0, rdo[0]}, 8'h0F);
        stop();
        chk("t1_idle_busy", {7'h0, busy},         8'h00);
        chk("t1_idle_oe",   {4'h0, qspi_data_oe}, 8'h00);

        // 2: write wraps FF->00, read wraps too
        start(8'h38, 24'h0000FF);
        send_byte(8'h11);
        send_byte(8'h22);
        stop();
        read_nibs(24'h0000FF, 4);
        chk("t2_n0", {4'h0, rd[0]}, 8'h01);
        chk("t2_n1", {4'h0, rd[1]}, 8'h01);
        chk("t2_n2", {4'h0, rd[2]}, 8'h02);
        chk("t2_n3", {4'h0, rd[3]}, 8'h02);
        stop();

        // 3: partial byte discarded
        start(8'h38, 24'h000020);
        send_byte(8'h5A);
        stop();
        start(8'h38, 24'h000020);
        pulse(4'h7, o, e);
        qspi_cs_n = 1'b1;
        wait_n(1);
        chk("t3_busy", {7'h0, busy},         8'h00);
        chk("t3_oe",   {4'h0, qspi_data_oe}, 8'h00);
        wait_n(1);
        read_nibs(24'h000020, 2);
        chk("t3_n0", {4'h0, rd[0]}, 8'h05);
        chk("t3_n1", {4'h0, rd[1]}, 8'h0A);
        stop();

        // 4: unknown opcode ignored, bad_cmd sticky
        qspi_cs_n = 1'b0;
        wait_n(2);
        send_byte(8'h9F);
        chk("t4_bad", {7'h0, bad_cmd}, 8'h01);
        for (int i = 0; i < 4; i++) begin
            pulse(4'hF, o, e);
            chk("t4_oe", {4'h0, e}, 8'h00);
        end
        stop();
        read_nibs(24'h000010, 2);
        chk("t4_n0",  {4'h0, rd[0]}, 8'h0A);
        chk("t4_n1",  {4'h0, rd[1]}, 8'h05);
        chk("t4_bad2", {7'h0, bad_cmd}, 8'h01);
        stop();

        // 5: reset during the second read byte
        read_nibs(24'h000010, 3);
        chk("t5_n2", {4'h0, rd[2]}, 8'h03);
        rst = 1'b1;
        wait_n(1);
        chk("t5_oe",   {4'h0, qspi_data_oe}, 8'h00);
        chk("t5_busy", {7'h0, busy},         8'h00);
        rst = 1'b0;
        stop();
        read_nibs(24'h000010, 4);
        chk("t5_r0", {4'h0, rd[0]}, 8'h0A);
        chk("t5_r3", {4'h0, rd[3]}, 8'h0C);
        stop();

`ifdef QSPI_RESP_LATENCY_EN
        begin
            int l0, l3;
            oe_latency(3'd0, l0);
            oe_latency(3'd3, l3);
            chk("t6_lat0",  8'(l0), 8'd1);
            chk("t6_delta", 8'(l3 - l0), 8'd3);
            latency_cfg = 3'd0;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    // Watchdog: the directed sequence is far shorter than this.
    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
